scan_seq_ctrl: RTL and testbench



---
 rtl/scan_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_scan_seq_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/scan_seq_ctrl.sv
// Scan chain sequencer: shift-only exchange or shift-in/capture/shift-out of up to MAXLEN cells.
// Latency N+1 cycles (shift-only) or 2N+2 (capture) from START; START is ignored while BUSY.
module scan_seq_ctrl #(
    parameter int MAXLEN = 32,
    parameter int LW     = 6
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              START,
    input  logic              CAPEN,
    input  logic [LW-1:0]     LEN,
    input  logic [MAXLEN-1:0] TXD,
    input  logic              SO,
    output logic              SD,
    output logic              SI,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [MAXLEN-1:0] RXD
);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, FIN} state_t;

    state_t            state;
    logic              capen_q;
    logic [LW-1:0]     n_q;
    logic [LW-1:0]     cnt;
    logic [MAXLEN-1:0] txd_q;
    logic [LW-1:0]     len_eff;
    logic              last;
    logic [MAXLEN-1:0] so_bit;

    assign len_eff = (LEN > LW'(MAXLEN)) ? LW'(MAXLEN) : LEN;
    assign last    = (cnt == n_q - LW'(1));
    // SO lands at the bit position of the current shift count
    assign so_bit  = {{(MAXLEN-1){1'b0}}, SO} << cnt;

    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state   <= IDLE;
            capen_q <= 1'b0;
            n_q     <= '0;
            cnt     <= '0;
            txd_q   <= '0;
            SD      <= 1'b0;
            SI      <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
            RXD     <= '0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (START) begin
                        capen_q <= CAPEN;
                        n_q     <= len_eff;
                        txd_q   <= TXD;
                        RXD     <= '0;
                        cnt     <= '0;
                        if (len_eff == '0) begin
                            state <= FIN;
                            DONE  <= 1'b1;
                            ERR   <= 1'b1;
                            SD    <= 1'b0;
                            SI    <= 1'b0;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= SHIFT_IN;
                            SD    <= 1'b1;
                            SI    <= TXD[0];
                            BUSY  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        SD    <= 1'b0;
                        SI    <= 1'b0;
                        BUSY  <= 1'b0;
                    end
                end
                SHIFT_IN: begin
                    RXD   <= RXD | so_bit;
                    txd_q <= txd_q >> 1;
                    if (last) begin
                        cnt <= '0;
                        SD  <= 1'b0;
                        SI  <= 1'b0;
                        if (capen_q) begin
                            state <= CAPTURE;
                        end else begin
                            state <= FIN;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + LW'(1);
                        SI  <= txd_q[1];
                    end
                end
                CAPTURE: begin
                    // chain loads D0 at this edge; the shift-in samples are discarded
                    cnt   <= '0;
                    RXD   <= '0;
                    state <= SHIFT_OUT;
                    SD    <= 1'b1;
                    SI    <= 1'b0;
                end
                SHIFT_OUT: begin
                    RXD <= RXD | so_bit;
                    if (last) begin
                        cnt   <= '0;
                        state <= FIN;
                        SD    <= 1'b0;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else begin
                        cnt <= cnt + LW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    SD    <= 1'b0;
                    SI    <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Bench for scan_seq_ctrl: behavioural mux-scan chain with constant D0, stream-based expected results.
module tb_scan_seq_ctrl;

    logic        ck, rstn, start, capen, so, sd, si, busy, done, err;
    logic [5:0]  len;
    logic [31:0] txd, rxd;

    logic [63:0] cells, d0;
    int          chain_len = 4;
    int          checks = 0;
    int          errors = 0;

    scan_seq_ctrl #(.MAXLEN(32), .LW(6)) dut (
        .CK(ck), .RSTN(rstn), .START(start), .CAPEN(capen), .LEN(len), .TXD(txd),
        .SO(so), .SD(sd), .SI(si), .BUSY(busy), .DONE(done), .ERR(err), .RXD(rxd)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Cells have no enable: shift when SD=1, otherwise load D0
    assign so = cells[chain_len-1];
    always @(posedge ck) cells <= sd ? {cells[62:0], si} : d0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_cmd(input logic c_en, input logic [5:0] c_len, input logic [31:0] c_txd,
                           input bit poke, input string tag);
        int          n, done_c;
        logic [31:0] exp_rxd;
        logic [63:0] exp_ch, mask;
        logic        exp_sd, exp_si;
        n      = (c_len > 6'd32) ? 32 : int'(c_len);
        done_c = (n == 0) ? 1 : (c_en ? 2*n + 2 : n + 1);
        // Bits leave tail-first: old chain contents, then whatever SI fed in
        for (int i = 0; i < 32; i++) begin
            if (i >= n) exp_rxd[i] = 1'b0;
            else if (i < chain_len) exp_rxd[i] = d0[chain_len-1-i];
            else exp_rxd[i] = c_en ? 1'b0 : c_txd[i-chain_len];
        end
        start = 1'b1; capen = c_en; len = c_len; txd = c_txd;
        @(posedge ck);
        #1;
        start = 1'b0; capen = 1'($urandom); len = 6'($urandom); txd = $urandom;
        for (int c = 1; c <= done_c; c++) begin
            @(negedge ck);
            exp_sd = (n > 0) && ((c <= n) || (c_en && c >= n + 2 && c <= 2*n + 1));
            exp_si = (c <= n) ? c_txd[c-1] : 1'b0;
            chk({tag, "/sd"}, 64'(sd), 64'(exp_sd));
            chk({tag, "/si"}, 64'(si), 64'(exp_si));
            chk({tag, "/busy"}, 64'(busy), 64'(c < done_c));
            chk({tag, "/done"}, 64'(done), 64'(c == done_c));
            if (poke && c == 1 && done_c > 2) begin
                start = 1'b1; capen = 1'($urandom); len = 6'($urandom_range(40, 0)); txd = $urandom;
            end
            if (c == 2) start = 1'b0;
        end
        chk({tag, "/err"}, 64'(err), 64'(n == 0));
        chk({tag, "/rxd"}, 64'(rxd), 64'(exp_rxd));
        if (!c_en && n > 0) begin
            exp_ch = '0;
            mask   = '0;
            for (int k = 0; k < chain_len; k++) begin
                mask[k]   = 1'b1;
                exp_ch[k] = (k < n) ? c_txd[n-1-k] : d0[k-n];
            end
            chk({tag, "/chain"}, cells & mask, exp_ch);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; capen = 1'b0; len = '0; txd = '0; d0 = '0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("rst/sd", 64'(sd), 64'(0));
        chk("rst/si", 64'(si), 64'(0));
        chk("rst/busy", 64'(busy), 64'(0));
        chk("rst/done", 64'(done), 64'(0));
        chk("rst/err", 64'(err), 64'(0));
        chk("rst/rxd", 64'(rxd), 64'(0));
        rstn = 1'b1;
        @(negedge ck);

        // Shift-only exchange on a 4-cell chain preloaded with 1010
        chain_len = 4; d0 = 64'b1010;
        @(negedge ck);
        run_cmd(1'b0, 6'd4, 32'b0110, 1'b0, "xchg");
        chk("xchg/rxd_const", 64'(rxd), 64'h5);
        chk("xchg/chain_const", cells & 64'hF, 64'b0110);
        repeat (2) @(negedge ck);

        // Capture with D0 = 1100
        d0 = 64'b1100;
        @(negedge ck);
        run_cmd(1'b1, 6'd4, 32'h0, 1'b0, "cap");
        chk("cap/rxd_const", 64'(rxd), 64'h3);
        repeat (2) @(negedge ck);

        run_cmd(1'b0, 6'd0, $urandom, 1'b0, "len0");
        chk("len0/rxd_const", 64'(rxd), 64'h0);
        repeat (2) @(negedge ck);

        chain_len = 40; d0 = {$urandom, $urandom};
        @(negedge ck);
        run_cmd(1'b0, 6'd40, $urandom, 1'b0, "clamp");
        repeat (2) @(negedge ck);

        // Reset in the middle of an 8-bit shift
        chain_len = 8; d0 = 64'hA5;
        start = 1'b1; capen = 1'b0; len = 6'd8; txd = $urandom;
        @(posedge ck);
        #1 start = 1'b0;
        @(negedge ck);
        @(negedge ck);
        rstn = 1'b0;
        @(negedge ck);
        rstn = 1'b1;
        chk("midrst/sd", 64'(sd), 64'(0));
        chk("midrst/busy", 64'(busy), 64'(0));
        chk("midrst/rxd", 64'(rxd), 64'(0));
        for (int c = 0; c < 10; c++) begin
            chk("midrst/nodone", 64'(done), 64'(0));
            @(negedge ck);
        end

        run_cmd(1'b1, 6'd6, $urandom, 1'b1, "poke");
        repeat (2) @(negedge ck);

        run_cmd(1'b0, 6'd3, $urandom, 1'b0, "b2b_a");
        run_cmd(1'b1, 6'd5, $urandom, 1'b0, "b2b_b");
        run_cmd(1'b0, 6'd0, $urandom, 1'b0, "b2b_c");
        run_cmd(1'b0, 6'd2, $urandom, 1'b0, "b2b_d");
        repeat (2) @(negedge ck);

        for (int t = 0; t < 30; t++) begin
            chain_len = $urandom_range(40, 1);
            d0 = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 0) @(negedge ck);
            run_cmd(1'($urandom), 6'($urandom_range(40, 0)), $urandom,
                    ($urandom_range(1, 0) == 1), $sformatf("rnd%0d", t));
            if ($urandom_range(1, 0) == 0) repeat ($urandom_range(3, 1)) @(negedge ck);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
